// File: rtl/fp_pkg.sv
// Shared binary32 field widths, operand struct and aligner FSM encoding
// for the single-precision adder datapath.
package fp_pkg;

  localparam int EXP_W     = 8;
  localparam int FRAC_W    = 23;
  localparam int SIG_W     = 27;
  localparam int MAX_ALIGN = 27;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } align_state_e;

  // Denormals share the exponent of the smallest normal and have no hidden bit.
  function automatic logic [EXP_W-1:0] eff_exp(input fp32_t x);
    return (x.exp == '0) ? EXP_W'(1) : x.exp;
  endfunction

  function automatic logic [FRAC_W:0] mant(input fp32_t x);
    return {x.exp != '0, x.frac};
  endfunction

endpackage

// File: rtl/fp_swap_sel.sv
// Combinational magnitude ordering of two binary32 operands: exponent first,
// significand as tie-break; equal magnitudes keep A as the big operand.
module fp_swap_sel
  import fp_pkg::*;
(
  input  fp32_t            a_i,
  input  fp32_t            b_i,
  output fp32_t            big_o,
  output fp32_t            small_o,
  output logic             swapped_o,
  output logic [EXP_W-1:0] diff_o
);

  logic [EXP_W-1:0]  ea, eb;
  logic [FRAC_W:0]   ma, mb;
  logic              a_less;

  assign ea = eff_exp(a_i);
  assign eb = eff_exp(b_i);
  assign ma = mant(a_i);
  assign mb = mant(b_i);

  assign a_less    = (ea < eb) || ((ea == eb) && (ma < mb));
  assign swapped_o = a_less;
  assign big_o     = a_less ? b_i : a_i;
  assign small_o   = a_less ? a_i : b_i;
  assign diff_o    = eff_exp(big_o) - eff_exp(small_o);

endmodule

// File: rtl/fp_add_align.sv
// Multi-cycle operand aligner: orders the operands by magnitude, then shifts the
// smaller significand right by the exponent difference, SHIFT_STEP bits per cycle.
module fp_add_align
  import fp_pkg::*;
#(
  parameter int SHIFT_STEP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       op_a,
  input  logic [31:0]       op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              swapped,
  output logic              sign_big,
  output logic              sign_small,
  output logic [EXP_W-1:0]  exp_out,
  output logic [SIG_W-1:0]  sig_big,
  output logic [SIG_W-1:0]  sig_small,
  output align_state_e      dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; the producer holds valid and data stable until that edge.

  localparam int REM_W = 5;

  fp32_t            a_in, b_in, big_w, small_w;
  logic             swap_w;
  logic [EXP_W-1:0] diff_w;
  logic [REM_W-1:0] rem_init;
  logic             accept;

  align_state_e     state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [SIG_W-1:0] sig_small_q, sig_small_d;
  logic [SIG_W-1:0] sig_big_q, sig_big_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic             sign_big_q, sign_big_d;
  logic             sign_small_q, sign_small_d;
  logic             swapped_q, swapped_d;

  logic [5:0]       step_w;
  logic [SIG_W:0]   mask_wide;
  logic [SIG_W-1:0] shifted_w;
  logic             sticky_w;
  logic [REM_W-1:0] rem_after;

  assign a_in = op_a;
  assign b_in = op_b;

  fp_swap_sel u_swap (
    .a_i       (a_in),
    .b_i       (b_in),
    .big_o     (big_w),
    .small_o   (small_w),
    .swapped_o (swap_w),
    .diff_o    (diff_w)
  );

  assign rem_init = (diff_w > EXP_W'(MAX_ALIGN)) ? REM_W'(MAX_ALIGN) : diff_w[REM_W-1:0];
  assign accept   = in_valid && (state_q == IDLE);

  // One shift step: bit 0 collects the new LSB plus everything shifted past it,
  // and since the old bit 0 is always included the sticky bit never clears.
  assign step_w    = (int'(rem_q) > SHIFT_STEP) ? 6'(SHIFT_STEP) : {1'b0, rem_q};
  assign shifted_w = sig_small_q >> step_w;
  assign mask_wide = {(SIG_W+1){1'b1}} << (step_w + 6'd1);
  assign sticky_w  = |(sig_small_q & ~mask_wide[SIG_W-1:0]);
  assign rem_after = rem_q - step_w[REM_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = (rem_init != '0) ? SHIFT : DONE;
      SHIFT:   if (rem_after == '0) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    dbg_state = state_q;
  end

  always_comb begin
    rem_d        = rem_q;
    sig_small_d  = sig_small_q;
    sig_big_d    = sig_big_q;
    exp_d        = exp_q;
    sign_big_d   = sign_big_q;
    sign_small_d = sign_small_q;
    swapped_d    = swapped_q;
    if (accept) begin
      rem_d        = rem_init;
      sig_small_d  = {mant(small_w), 3'b000};
      sig_big_d    = {mant(big_w), 3'b000};
      exp_d        = eff_exp(big_w);
      sign_big_d   = big_w.sign;
      sign_small_d = small_w.sign;
      swapped_d    = swap_w;
    end else if (state_q == SHIFT) begin
      rem_d       = rem_after;
      sig_small_d = {shifted_w[SIG_W-1:1], sticky_w};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q        <= '0;
      sig_small_q  <= '0;
      sig_big_q    <= '0;
      exp_q        <= '0;
      sign_big_q   <= 1'b0;
      sign_small_q <= 1'b0;
      swapped_q    <= 1'b0;
    end else begin
      rem_q        <= rem_d;
      sig_small_q  <= sig_small_d;
      sig_big_q    <= sig_big_d;
      exp_q        <= exp_d;
      sign_big_q   <= sign_big_d;
      sign_small_q <= sign_small_d;
      swapped_q    <= swapped_d;
    end
  end

  assign swapped    = swapped_q;
  assign sign_big   = sign_big_q;
  assign sign_small = sign_small_q;
  assign exp_out    = exp_q;
  assign sig_big    = sig_big_q;
  assign sig_small  = sig_small_q;

endmodule
